// File: rtl/memory_access_unit.sv
// memory_access_unit
//   MEM stage of the 5-stage RV64 pipeline. Accepts the EX/MEM payload,
//   issues at most one load/store on the data bus (valid/addr_ok/data_ok
//   handshake) and produces the write-back payload for the MEM/WB register.
//   Upstream is held off through in_ready while a bus transaction is open.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        EX/MEM payload handshake
//   in_mem_read, in_mem_write  load / store select (mutually exclusive)
//   in_size, in_unsigned       access size (B/H/W/D) and zero-extend flag
//   in_addr, in_wdata          effective address, store data (low bytes)
//   in_rd, in_regwrite         destination register and its write enable
//   dreq_*                     bus request: valid, addr, strobe, data, size
//   dresp_*                    bus response: addr_ok, data_ok, read data
//   out_*                      write-back payload, out_valid is a 1-cycle pulse
module memory_access_unit #(
    parameter int XLEN  = 64,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mem_read,
    input  logic             in_mem_write,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    input  logic [XLEN-1:0]  in_addr,
    input  logic [XLEN-1:0]  in_wdata,
    input  logic [REG_W-1:0] in_rd,
    input  logic             in_regwrite,
    output logic             dreq_valid,
    output logic [XLEN-1:0]  dreq_addr,
    output logic [7:0]       dreq_strobe,
    output logic [XLEN-1:0]  dreq_data,
    output logic [1:0]       dreq_size,
    input  logic             dresp_addr_ok,
    input  logic             dresp_data_ok,
    input  logic [XLEN-1:0]  dresp_data,
    output logic             out_valid,
    output logic [REG_W-1:0] out_rd,
    output logic             out_regwrite,
    output logic [XLEN-1:0]  out_result,
    output logic             out_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state;

    // Payload kept for the duration of a bus transaction
    logic [REG_W-1:0] rd_p1;
    logic             regwrite_p1;
    logic             isLoad_p1;
    logic             unsigned_p1;
    logic [1:0]       size_p1;
    logic [2:0]       off_p1;

    logic accept;
    logic isMemOp;
    logic respDone;

    function automatic logic [7:0] byteMask(input logic [1:0] size);
        case (size)
            2'd0:    byteMask = 8'h01;
            2'd1:    byteMask = 8'h03;
            2'd2:    byteMask = 8'h0F;
            default: byteMask = 8'hFF;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd0:    isMisaligned = 1'b0;
            2'd1:    isMisaligned = off[0];
            2'd2:    isMisaligned = |off[1:0];
            default: isMisaligned = |off;
        endcase
    endfunction

    // Bring the addressed lane down to bit 0, then truncate and extend.
    // Doublewords have nothing to extend, so in_unsigned is irrelevant there.
    function automatic logic [XLEN-1:0] loadExtend(input logic [XLEN-1:0] raw,
                                                   input logic [2:0]      off,
                                                   input logic [1:0]      size,
                                                   input logic            uns);
        logic [XLEN-1:0] tmp;
        tmp = raw >> {off, 3'b000};
        case (size)
            2'd0:    loadExtend = {{(XLEN-8){tmp[7] & ~uns}}, tmp[7:0]};
            2'd1:    loadExtend = {{(XLEN-16){tmp[15] & ~uns}}, tmp[15:0]};
            2'd2:    loadExtend = {{(XLEN-32){tmp[31] & ~uns}}, tmp[31:0]};
            default: loadExtend = tmp;
        endcase
    endfunction

    // Reset is folded in so in_ready reads 0 while reset is held
    assign in_ready = (state == IDLE) && !reset;
    assign accept   = in_valid && in_ready;
    assign isMemOp  = in_mem_read || in_mem_write;

    // data_ok arriving before addr_ok (still in REQ) is not a completion
    assign respDone = ((state == REQ) && dresp_addr_ok && dresp_data_ok) ||
                      ((state == RESP) && dresp_data_ok);

    // Stage p1: payload capture on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_p1       <= in_rd;
            regwrite_p1 <= in_regwrite;
            isLoad_p1   <= in_mem_read;
            unsigned_p1 <= in_unsigned;
            size_p1     <= in_size;
            off_p1      <= in_addr[2:0];
        end
    end

    // Stage p1/p2: bus sequencing and write-back payload
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dreq_valid   <= 1'b0;
            dreq_addr    <= '0;
            dreq_strobe  <= '0;
            dreq_data    <= '0;
            dreq_size    <= '0;
            out_valid    <= 1'b0;
            out_rd       <= '0;
            out_regwrite <= 1'b0;
            out_result   <= '0;
            out_misalign <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (!isMemOp) begin
                            out_valid    <= 1'b1;
                            out_rd       <= in_rd;
                            out_regwrite <= in_regwrite;
                            out_result   <= in_addr;
                            out_misalign <= 1'b0;
                        end else if (isMisaligned(in_size, in_addr[2:0])) begin
                            // Faulting address is reported as the result
                            out_valid    <= 1'b1;
                            out_rd       <= in_rd;
                            out_regwrite <= 1'b0;
                            out_result   <= in_addr;
                            out_misalign <= 1'b1;
                        end else begin
                            state       <= REQ;
                            dreq_valid  <= 1'b1;
                            dreq_addr   <= in_addr;
                            dreq_strobe <= in_mem_write ? (byteMask(in_size) << in_addr[2:0]) : 8'h00;
                            dreq_data   <= in_wdata << {in_addr[2:0], 3'b000};
                            dreq_size   <= in_size;
                        end
                    end
                end
                REQ: begin
                    if (dresp_addr_ok) begin
                        dreq_valid <= 1'b0;
                        state      <= dresp_data_ok ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (dresp_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (respDone) begin
                out_valid    <= 1'b1;
                out_rd       <= rd_p1;
                out_regwrite <= isLoad_p1 && regwrite_p1;
                out_result   <= isLoad_p1 ? loadExtend(dresp_data, off_p1, size_p1, unsigned_p1) : '0;
                out_misalign <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic [1:0]  dreq_size;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic [63:0] out_result;
    logic        out_misalign;

    int errCount   = 0;
    int checkCount = 0;

    memory_access_unit #(.XLEN(64), .REG_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_size      (in_size),
        .in_unsigned  (in_unsigned),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_rd        (in_rd),
        .in_regwrite  (in_regwrite),
        .dreq_valid   (dreq_valid),
        .dreq_addr    (dreq_addr),
        .dreq_strobe  (dreq_strobe),
        .dreq_data    (dreq_data),
        .dreq_size    (dreq_size),
        .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok),
        .dresp_data   (dresp_data),
        .out_valid    (out_valid),
        .out_rd       (out_rd),
        .out_regwrite (out_regwrite),
        .out_result   (out_result),
        .out_misalign (out_misalign)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference model: byte-level view of the access
    function automatic int numBytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic bit modelMisaligned(input logic [1:0] size, input logic [63:0] addr);
        return (addr % numBytes(size)) != 0;
    endfunction

    function automatic logic [63:0] modelLoad(input logic [63:0] raw, input logic [63:0] addr,
                                              input logic [1:0] size, input bit uns);
        logic [63:0] v;
        int nb;
        int off;
        nb  = numBytes(size);
        off = int'(addr % 8);
        v   = 64'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = raw[8*(off+i) +: 8];
        if (!uns && nb < 8 && v[8*nb-1]) begin
            for (int i = 8*nb; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [7:0] modelStrobe(input logic [63:0] addr, input logic [1:0] size);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < numBytes(size); i++) s[int'(addr % 8) + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] modelWdata(input logic [63:0] wd, input logic [63:0] addr);
        logic [63:0] d;
        int off;
        off = int'(addr % 8);
        d = 64'd0;
        for (int j = off; j < 8; j++) d[8*j +: 8] = wd[8*(j-off) +: 8];
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // op: 0 = ALU pass-through, 1 = load, 2 = store
    // dA: cycles before addr_ok; dD: cycles from addr_ok to data_ok (0 = same cycle)
    task automatic doTxn(input int op, input logic [1:0] size, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [4:0] rd, input bit we, input logic [63:0] rdata,
                         input int dA, input int dD, input bit earlyDataOk);
        int n;
        bit mis;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checkVal("ready_wait", {63'd0, in_ready}, 64'd1);

        in_valid     = 1'b1;
        in_mem_read  = (op == 1);
        in_mem_write = (op == 2);
        in_size      = size;
        in_unsigned  = uns;
        in_addr      = addr;
        in_wdata     = wdata;
        in_rd        = rd;
        in_regwrite  = we;
        tick();
        in_valid     = 1'b0;
        in_addr      = $urandom;
        in_wdata     = {$urandom, $urandom};

        mis = (op != 0) && modelMisaligned(size, addr);
        if (op == 0 || mis) begin
            checkVal("imm_valid", {63'd0, out_valid}, 64'd1);
            checkVal("imm_misalign", {63'd0, out_misalign}, {63'd0, mis});
            checkVal("imm_we", {63'd0, out_regwrite}, {63'd0, (op == 0) && we});
            checkVal("imm_rd", {59'd0, out_rd}, {59'd0, rd});
            if (op == 0) checkVal("imm_result", out_result, addr);
            checkVal("imm_noreq", {63'd0, dreq_valid}, 64'd0);
            checkVal("imm_ready", {63'd0, in_ready}, 64'd1);
            tick();
            checkVal("imm_pulse", {63'd0, out_valid}, 64'd0);
            return;
        end

        checkVal("req_valid", {63'd0, dreq_valid}, 64'd1);
        checkVal("req_addr", dreq_addr, addr);
        checkVal("req_strobe", {56'd0, dreq_strobe}, (op == 2) ? {56'd0, modelStrobe(addr, size)} : 64'd0);
        if (op == 2) checkVal("req_data", dreq_data, modelWdata(wdata, addr));
        checkVal("req_size", {62'd0, dreq_size}, {62'd0, size});
        checkVal("req_busy", {63'd0, in_ready}, 64'd0);

        for (int k = 0; k < dA; k++) begin
            dresp_data_ok = earlyDataOk && (k == 0);
            dresp_data    = {$urandom, $urandom};
            tick();
            dresp_data_ok = 1'b0;
            checkVal("hold_valid", {63'd0, dreq_valid}, 64'd1);
            checkVal("hold_addr", dreq_addr, addr);
            checkVal("hold_strobe", {56'd0, dreq_strobe}, (op == 2) ? {56'd0, modelStrobe(addr, size)} : 64'd0);
            checkVal("hold_busy", {63'd0, in_ready}, 64'd0);
            checkVal("hold_noout", {63'd0, out_valid}, 64'd0);
        end

        dresp_addr_ok = 1'b1;
        if (dD == 0) begin
            dresp_data_ok = 1'b1;
            dresp_data    = rdata;
        end
        tick();
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;

        if (dD > 0) begin
            checkVal("resp_reqdrop", {63'd0, dreq_valid}, 64'd0);
            checkVal("resp_noout", {63'd0, out_valid}, 64'd0);
            for (int k = 0; k < dD - 1; k++) begin
                dresp_data = {$urandom, $urandom};
                tick();
                checkVal("resp_busy", {63'd0, in_ready}, 64'd0);
                checkVal("resp_noout", {63'd0, out_valid}, 64'd0);
            end
            dresp_data_ok = 1'b1;
            dresp_data    = rdata;
            tick();
            dresp_data_ok = 1'b0;
        end

        checkVal("done_valid", {63'd0, out_valid}, 64'd1);
        checkVal("done_we", {63'd0, out_regwrite}, {63'd0, (op == 1) && we});
        checkVal("done_rd", {59'd0, out_rd}, {59'd0, rd});
        checkVal("done_misalign", {63'd0, out_misalign}, 64'd0);
        if (op == 1) checkVal("done_result", out_result, modelLoad(rdata, addr, size, uns));
        checkVal("done_ready", {63'd0, in_ready}, 64'd1);
        checkVal("done_noreq", {63'd0, dreq_valid}, 64'd0);
        tick();
        checkVal("done_pulse", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] a;
        int op;
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        in_size       = 2'd0;
        in_unsigned   = 1'b0;
        in_addr       = '0;
        in_wdata      = '0;
        in_rd         = '0;
        in_regwrite   = 1'b0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;

        tick();
        tick();
        checkVal("rst_outvalid", {63'd0, out_valid}, 64'd0);
        checkVal("rst_dreqvalid", {63'd0, dreq_valid}, 64'd0);
        checkVal("rst_result", out_result, 64'd0);
        checkVal("rst_strobe", {56'd0, dreq_strobe}, 64'd0);
        checkVal("rst_ready", {63'd0, in_ready}, 64'd0);
        reset = 1'b0;
        #1;
        checkVal("rst_ready_after", {63'd0, in_ready}, 64'd1);

        // Directed scenarios
        doTxn(0, 2'd3, 1'b0, 64'h1234, 64'd0, 5'd5, 1'b1, 64'd0, 0, 0, 1'b0);
        doTxn(1, 2'd0, 1'b0, 64'h1003, 64'd0, 5'd7, 1'b1, 64'h0000_0000_80FF_0000, 1, 1, 1'b0);
        checkVal("lb_constant", modelLoad(64'h0000_0000_80FF_0000, 64'h1003, 2'd0, 1'b0), 64'hFFFF_FFFF_FFFF_FF80);
        doTxn(2, 2'd1, 1'b0, 64'h2006, 64'hBEEF, 5'd0, 1'b0, 64'd0, 0, 1, 1'b0);
        doTxn(1, 2'd2, 1'b0, 64'h3002, 64'd0, 5'd9, 1'b1, 64'd0, 0, 0, 1'b0);
        doTxn(1, 2'd3, 1'b0, 64'h4008, 64'd0, 5'd11, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 3, 2, 1'b1);

        // Reset while waiting in RESP
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0;
        in_size = 2'd3; in_addr = 64'h6000; in_rd = 5'd3; in_regwrite = 1'b1;
        tick();
        in_valid = 1'b0;
        dresp_addr_ok = 1'b1;
        tick();
        dresp_addr_ok = 1'b0;
        checkVal("rresp_reqdrop", {63'd0, dreq_valid}, 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checkVal("rresp_dreq", {63'd0, dreq_valid}, 64'd0);
        checkVal("rresp_noout", {63'd0, out_valid}, 64'd0);
        checkVal("rresp_ready", {63'd0, in_ready}, 64'd1);
        dresp_data_ok = 1'b1;
        dresp_data    = 64'h1111_2222_3333_4444;
        tick();
        dresp_data_ok = 1'b0;
        checkVal("rresp_stale", {63'd0, out_valid}, 64'd0);
        doTxn(1, 2'd0, 1'b1, 64'h5005, 64'd0, 5'd12, 1'b1, 64'h0000_9A00_0000_0000, 1, 0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            op = int'($urandom_range(0, 2));
            a  = {$urandom, $urandom};
            doTxn(op, 2'($urandom_range(0, 3)), 1'($urandom), a, {$urandom, $urandom},
                  5'($urandom), 1'($urandom), {$urandom, $urandom},
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
